dwc_upconv_rd_credit_ctrl: RTL and testbench

DWC_UPCONV_RD_CREDIT_CTRL -- requirements
Module: dwc_upconv_rd_credit_ctrl

---
 rtl/dwc_upconv_rd_credit_ctrl.sv | 123 ++++++++++++
 tb/tb_dwc_upconv_rd_credit_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwc_upconv_rd_credit_ctrl.sv
// Read-side credit controller for an AXI width up-converter.
// A converted read address is accepted only when the R data FIFO has room
// for the whole slave-side burst (credits), the in-flight burst limit
// allows it, and the R command FIFO can take one more entry. An accepted
// address is held on arvalid_out until the slave handshakes it, at which
// point one command-FIFO push is strobed and the burst becomes outstanding.
//
// Ports:
//   ACLK, sysReset      clock, asynchronous active-high reset
//   arvalid_in          upstream converted read address valid
//   arlen_slv           slave-side burst length minus one
//   arready_out         upstream address accepted (combinational)
//   arvalid_out         registered read address valid toward slave
//   arready_in          slave read address ready
//   cmd_fifo_full       R command FIFO nearly full (gates acceptance only)
//   wr_en_cmd           R command FIFO push strobe (combinational)
//   data_fifo_rd        one data FIFO entry freed this cycle
//   burst_done          master-side RLAST handshake completed
//   credits             free data FIFO entries not yet reserved
//   outstanding         bursts issued to the slave and not yet completed
//   err_overflow        sticky: credit release above depth, or burst_done
//                       with nothing outstanding
module dwc_upconv_rd_credit_ctrl #(
  parameter int unsigned DATA_FIFO_DEPTH = 1024,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                       ACLK,
  input  logic                                       sysReset,
  input  logic                                       arvalid_in,
  input  logic [7:0]                                 arlen_slv,
  output logic                                       arready_out,
  output logic                                       arvalid_out,
  input  logic                                       arready_in,
  input  logic                                       cmd_fifo_full,
  output logic                                       wr_en_cmd,
  input  logic                                       data_fifo_rd,
  input  logic                                       burst_done,
  output logic [$clog2(DATA_FIFO_DEPTH+1)-1:0]       credits,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
  output logic                                       err_overflow
);

  localparam int unsigned CW   = $clog2(DATA_FIFO_DEPTH + 1);
  localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);
  // Compare width: at least 9 bits so arlen_slv+1 = 256 is representable.
  localparam int unsigned CMPW = (CW > 9) ? CW : 9;
  localparam int unsigned SW   = CMPW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic            pending;
  logic            arvalid_q;

  logic [CMPW-1:0] need;
  logic            credit_ok;
  logic            slot_ok;
  logic            accept;
  logic            issue;
  logic [SW-1:0]   cred_sum;
  logic [CW-1:0]   credits_nxt;
  logic            cred_ovf;
  logic            done_ok;
  logic            done_err;
  logic [OW-1:0]   outstanding_nxt;

  assign arvalid_out = arvalid_q;

  always_comb begin
    need      = CMPW'(arlen_slv) + CMPW'(1);
    // Second term rejects bursts that could never fit, even with an empty FIFO.
    credit_ok = (CMPW'(credits) >= need) && (need <= CMPW'(DATA_FIFO_DEPTH));
    slot_ok   = (32'(outstanding) + 32'(pending)) < 32'(MAX_OUTSTANDING);

    arready_out = (state == IDLE) && arvalid_in && credit_ok && slot_ok && !cmd_fifo_full;
    accept      = arready_out;
    issue       = (state == ISSUE) && arvalid_q && arready_in;
    wr_en_cmd   = issue;

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Reserve never exceeds current credits (accept guarantees it), so the
    // sum cannot underflow; only the release side can overshoot.
    cred_sum    = SW'(credits) - (accept ? SW'(need) : '0) + SW'(data_fifo_rd);
    cred_ovf    = cred_sum > SW'(DATA_FIFO_DEPTH);
    credits_nxt = cred_ovf ? CW'(DATA_FIFO_DEPTH) : CW'(cred_sum);

    done_ok         = burst_done && (outstanding != '0);
    done_err        = burst_done && (outstanding == '0);
    outstanding_nxt = outstanding + OW'(issue) - OW'(done_ok);
  end

  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      state        <= IDLE;
      arvalid_q    <= 1'b0;
      pending      <= 1'b0;
      credits      <= CW'(DATA_FIFO_DEPTH);
      outstanding  <= '0;
      err_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      arvalid_q   <= (state_nxt == ISSUE);
      credits     <= credits_nxt;
      outstanding <= outstanding_nxt;
      if (accept)
        pending <= 1'b1;
      else if (issue)
        pending <= 1'b0;
      if (cred_ovf || done_err)
        err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dwc_upconv_rd_credit_ctrl.sv
module tb_dwc_upconv_rd_credit_ctrl;

  localparam int DEPTH = 16;
  localparam int MAXO  = 4;

  logic       ACLK;
  logic       sysReset;
  logic       arvalid_in;
  logic [7:0] arlen_slv;
  logic       arready_out;
  logic       arvalid_out;
  logic       arready_in;
  logic       cmd_fifo_full;
  logic       wr_en_cmd;
  logic       data_fifo_rd;
  logic       burst_done;
  logic [4:0] credits;
  logic [2:0] outstanding;
  logic       err_overflow;

  int checks = 0;
  int errors = 0;

  dwc_upconv_rd_credit_ctrl #(
    .DATA_FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .ACLK(ACLK),
    .sysReset(sysReset),
    .arvalid_in(arvalid_in),
    .arlen_slv(arlen_slv),
    .arready_out(arready_out),
    .arvalid_out(arvalid_out),
    .arready_in(arready_in),
    .cmd_fifo_full(cmd_fifo_full),
    .wr_en_cmd(wr_en_cmd),
    .data_fifo_rd(data_fifo_rd),
    .burst_done(burst_done),
    .credits(credits),
    .outstanding(outstanding),
    .err_overflow(err_overflow)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       av;
    logic [7:0] len;
    logic       ri;
    logic       full;
    logic       rd;
    logic       done;
    logic       e_ar;
    logic       e_avo;
    logic       e_wr;
    int         e_cred;
    int         e_out;
    logic       e_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ar, input int avo, input int wr,
                         input int cred, input int outs, input int err);
    chk({tag, " arready_out"},  int'(arready_out),  ar);
    chk({tag, " arvalid_out"},  int'(arvalid_out),  avo);
    chk({tag, " wr_en_cmd"},    int'(wr_en_cmd),    wr);
    chk({tag, " credits"},      int'(credits),      cred);
    chk({tag, " outstanding"},  int'(outstanding),  outs);
    chk({tag, " err_overflow"}, int'(err_overflow), err);
  endtask

  // Drive one cycle's inputs at the falling edge, settle, then return.
  task automatic apply(input logic av, input logic [7:0] len, input logic ri,
                       input logic full, input logic rd, input logic done);
    @(negedge ACLK);
    arvalid_in    = av;
    arlen_slv     = len;
    arready_in    = ri;
    cmd_fifo_full = full;
    data_fifo_rd  = rd;
    burst_done    = done;
    #1;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    sysReset      = 1'b1;
    arvalid_in    = 1'b0;
    arlen_slv     = '0;
    arready_in    = 1'b0;
    cmd_fifo_full = 1'b0;
    data_fifo_rd  = 1'b0;
    burst_done    = 1'b0;
    @(negedge ACLK);
    sysReset = 1'b0;
    #1;
  endtask

  // Reference model state: is an address being presented to the slave,
  // free credits, bursts in flight, sticky error.
  bit m_busy;
  int m_cred;
  int m_out;
  bit m_err;

  task automatic model_reset();
    m_busy = 0;
    m_cred = DEPTH;
    m_out  = 0;
    m_err  = 0;
  endtask

  initial begin
    sysReset      = 1'b1;
    arvalid_in    = 1'b0;
    arlen_slv     = '0;
    arready_in    = 1'b0;
    cmd_fifo_full = 1'b0;
    data_fifo_rd  = 1'b0;
    burst_done    = 1'b0;

    //            av len ri fu rd dn | ar avo wr cred out err
    tbl[0]  = '{1, 3,  1, 0, 0, 0,   1, 0, 0, 16, 0, 0};
    tbl[1]  = '{0, 0,  1, 0, 0, 0,   0, 1, 1, 12, 0, 0};
    tbl[2]  = '{0, 0,  1, 0, 0, 0,   0, 0, 0, 12, 1, 0};
    tbl[3]  = '{0, 0,  0, 0, 1, 0,   0, 0, 0, 12, 1, 0};
    tbl[4]  = '{0, 0,  0, 0, 0, 1,   0, 0, 0, 13, 1, 0};
    tbl[5]  = '{0, 0,  0, 0, 0, 0,   0, 0, 0, 13, 0, 0};
    tbl[6]  = '{1, 15, 0, 0, 0, 0,   0, 0, 0, 13, 0, 0};
    tbl[7]  = '{1, 12, 0, 1, 0, 0,   0, 0, 0, 13, 0, 0};
    tbl[8]  = '{1, 12, 0, 0, 0, 0,   1, 0, 0, 13, 0, 0};
    tbl[9]  = '{0, 0,  0, 0, 0, 0,   0, 1, 0, 0,  0, 0};
    tbl[10] = '{0, 0,  1, 1, 0, 0,   0, 1, 1, 0,  0, 0};
    tbl[11] = '{0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  1, 0};

    // Reset state
    do_reset();
    chk_all("reset", 0, 0, 0, 16, 0, 0);

    // Vector table: single burst, credit release, done, oversize/full gating
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].av, tbl[i].len, tbl[i].ri, tbl[i].full, tbl[i].rd, tbl[i].done);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].e_ar), int'(tbl[i].e_avo),
              int'(tbl[i].e_wr), tbl[i].e_cred, tbl[i].e_out, int'(tbl[i].e_err));
    end

    // Outstanding limit
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1, 0, 1, 0, 0, 0);
      chk($sformatf("lim accept%0d", k), int'(arready_out), 1);
      apply(0, 0, 1, 0, 0, 0);
      chk($sformatf("lim wr%0d", k), int'(wr_en_cmd), 1);
    end
    apply(1, 0, 1, 0, 0, 0);
    chk("lim fifth blocked", int'(arready_out), 0);
    chk("lim outstanding", int'(outstanding), 4);
    apply(1, 0, 1, 0, 0, 1);
    chk("lim blocked during done", int'(arready_out), 0);
    apply(1, 0, 1, 0, 0, 0);
    chk("lim outstanding after done", int'(outstanding), 3);
    chk("lim accept after done", int'(arready_out), 1);

    // Credit stall and simultaneous reserve/release
    do_reset();
    apply(1, 11, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(1, 4, 0, 0, 0, 0);
    chk("cred stall credits", int'(credits), 4);
    chk("cred stall", int'(arready_out), 0);
    apply(1, 4, 0, 0, 1, 0);
    chk("cred stall with rd", int'(arready_out), 0);
    apply(1, 4, 0, 0, 1, 0);
    chk("cred after rd", int'(credits), 5);
    chk("cred accept", int'(arready_out), 1);
    apply(0, 0, 1, 0, 0, 0);
    chk("cred reserve+rd", int'(credits), 1);

    // Slave holds off arready_in for 10 cycles
    do_reset();
    apply(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      apply(1, 0, 0, 0, 0, 0);
      chk($sformatf("hold%0d arvalid_out", k), int'(arvalid_out), 1);
      chk($sformatf("hold%0d arready_out", k), int'(arready_out), 0);
      chk($sformatf("hold%0d wr_en_cmd", k), int'(wr_en_cmd), 0);
    end
    apply(0, 0, 1, 1, 0, 0);
    chk("hold handshake wr", int'(wr_en_cmd), 1);
    apply(0, 0, 0, 0, 0, 0);
    chk_all("hold after", 0, 0, 0, 15, 1, 0);

    // Release at full credits
    do_reset();
    apply(0, 0, 0, 0, 1, 0);
    chk("ovf pre err", int'(err_overflow), 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("ovf credits", int'(credits), 16);
    chk("ovf err", int'(err_overflow), 1);
    repeat (3) apply(0, 0, 0, 0, 0, 0);
    chk("ovf err sticky", int'(err_overflow), 1);
    do_reset();
    chk("ovf err cleared", int'(err_overflow), 0);

    // burst_done with nothing outstanding
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("done underflow outstanding", int'(outstanding), 0);
    chk("done underflow err", int'(err_overflow), 1);

    // Reset mid-ISSUE
    do_reset();
    apply(1, 3, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("rst mid arvalid_out", int'(arvalid_out), 1);
    chk("rst mid credits", int'(credits), 12);
    #1;
    sysReset   = 1'b1;
    arready_in = 1'b1;
    #1;
    chk_all("rst async", 0, 0, 0, 16, 0, 0);
    @(negedge ACLK);
    sysReset = 1'b0;
    apply(0, 0, 1, 0, 0, 0);
    chk_all("rst after", 0, 0, 0, 16, 0, 0);

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic       av, ri, full, rd, done;
      logic [7:0] len;
      bit         e_acc, e_issue;
      if (i % 300 == 0) begin
        do_reset();
        model_reset();
      end
      av   = ($urandom_range(0, 3) != 0);
      len  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 7));
      ri   = $urandom_range(0, 1) == 1;
      full = ($urandom_range(0, 4) == 0);
      rd   = ($urandom_range(0, 9) < 4);
      done = ($urandom_range(0, 3) == 0);
      apply(av, len, ri, full, rd, done);

      e_acc   = !m_busy && av && (m_cred >= int'(len) + 1)
                && (m_out + int'(m_busy) < MAXO) && !full;
      e_issue = m_busy && ri;
      chk_all($sformatf("rnd%0d", i), int'(e_acc), int'(m_busy), int'(e_issue),
              m_cred, m_out, int'(m_err));

      if (e_acc) begin
        m_busy = 1;
        m_cred = m_cred - (int'(len) + 1);
      end else if (e_issue) begin
        m_busy = 0;
      end
      m_cred = m_cred + int'(rd);
      if (m_cred > DEPTH) begin
        m_cred = DEPTH;
        m_err  = 1;
      end
      if (done) begin
        if (m_out == 0) m_err = 1;
        else            m_out = m_out - 1;
      end
      if (e_issue) m_out = m_out + 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
